// File: rtl/matrix_pkg.sv
// Shared types and defaults for the random matrix fill controller.
package matrix_pkg;

  localparam int MAX_DIM   = 5;
  localparam int ELEM_W    = 4;
  localparam int MAX_RETRY = 4;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DRAW,
    SAMPLE,
    WRITE,
    FINISH
  } rand_fill_state_t;

endpackage

// File: rtl/rand_range_map.sv
// Maps a raw random sample onto [val_min, val_max]: direct accept when the
// sample fits the range, otherwise a modulo fold used as the retry fallback.
module rand_range_map #(
  parameter int ELEM_W   = 4,
  parameter int SAMPLE_W = 4
) (
  input  logic [ELEM_W-1:0]   val_min_i,
  input  logic [ELEM_W-1:0]   val_max_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                accept_o,
  output logic [ELEM_W-1:0]   data_o
);

  localparam int RW = ((ELEM_W > SAMPLE_W) ? ELEM_W : SAMPLE_W) + 1;

  logic [RW-1:0] range_w;
  logic [RW-1:0] sample_w;
  logic [RW-1:0] offset_w;

  always_comb begin
    range_w = RW'(val_max_i) - RW'(val_min_i) + RW'(1);
    // Only reachable with inverted bounds, which never reach sampling;
    // keeps the modulo well defined.
    if (range_w == '0) begin
      range_w = RW'(1);
    end
    sample_w = RW'(sample_i);
    accept_o = (sample_w < range_w);
    offset_w = accept_o ? sample_w : (sample_w % range_w);
    data_o   = val_min_i + offset_w[ELEM_W-1:0];
  end

endmodule

// File: rtl/rand_fill_ctrl.sv
// Fills a rows x cols matrix in row-major order with bounded random values
// drawn from an external shared LFSR, using rejection sampling with a fallback.
module rand_fill_ctrl #(
  parameter int MAX_DIM   = matrix_pkg::MAX_DIM,
  parameter int ELEM_W    = matrix_pkg::ELEM_W,
  parameter int MAX_RETRY = matrix_pkg::MAX_RETRY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        rows,
  input  logic [2:0]        cols,
  input  logic [ELEM_W-1:0] val_min,
  input  logic [ELEM_W-1:0] val_max,
  output logic              lfsr_en,
  input  logic [7:0]        lfsr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [2:0]        wr_row,
  output logic [2:0]        wr_col,
  output logic [ELEM_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import matrix_pkg::*;

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  rand_fill_state_t state_q, state_d;
  logic [2:0]         rows_q, rows_d;
  logic [2:0]         cols_q, cols_d;
  logic [ELEM_W-1:0]  min_q, min_d;
  logic [ELEM_W-1:0]  max_q, max_d;
  logic [2:0]         row_q, row_d;
  logic [2:0]         col_q, col_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [ELEM_W-1:0]  data_q, data_d;

  logic              map_accept;
  logic [ELEM_W-1:0] map_data;
  logic              params_bad;
  logic              last_col;
  logic              last_row;
  logic              unused_lfsr_hi;

  // Only the low nibble of the shared LFSR is consumed here.
  assign unused_lfsr_hi = ^lfsr_data[7:4];

  rand_range_map #(
    .ELEM_W   (ELEM_W),
    .SAMPLE_W (4)
  ) u_map (
    .val_min_i (min_q),
    .val_max_i (max_q),
    .sample_i  (lfsr_data[3:0]),
    .accept_o  (map_accept),
    .data_o    (map_data)
  );

  assign params_bad = (rows_q == 3'd0) || (cols_q == 3'd0) ||
                      (int'(rows_q) > MAX_DIM) || (int'(cols_q) > MAX_DIM) ||
                      (min_q > max_q);
  assign last_col   = (col_q == cols_q - 3'd1);
  assign last_row   = (row_q == rows_q - 3'd1);

  assign busy    = (state_q != IDLE);
  assign wr_row  = row_q;
  assign wr_col  = col_q;
  assign wr_data = data_q;

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    min_d    = min_q;
    max_d    = max_q;
    row_d    = row_q;
    col_d    = col_q;
    retry_d  = retry_q;
    data_d   = data_q;
    lfsr_en  = 1'b0;
    wr_valid = 1'b0;
    done     = 1'b0;
    err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d  = rows;
          cols_d  = cols;
          min_d   = val_min;
          max_d   = val_max;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (params_bad) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          row_d   = 3'd0;
          col_d   = 3'd0;
          retry_d = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        lfsr_en = 1'b1;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        if (map_accept || (retry_q == RETRY_W'(MAX_RETRY))) begin
          data_d  = map_data;
          state_d = WRITE;
        end else begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = DRAW;
        end
      end
      WRITE: begin
        wr_valid = 1'b1;
        if (wr_ready) begin
          retry_d = '0;
          if (last_col && last_row) begin
            state_d = FINISH;
          end else begin
            state_d = DRAW;
            if (last_col) begin
              col_d = 3'd0;
              row_d = row_q + 3'd1;
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over every other event, including a pending handshake.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      row_d   = row_q;
      col_d   = col_q;
      retry_d = retry_q;
      data_d  = data_q;
      done    = 1'b0;
      err     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      min_q   <= '0;
      max_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      retry_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      min_q   <= min_d;
      max_q   <= max_d;
      row_q   <= row_d;
      col_q   <= col_d;
      retry_q <= retry_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_rand_fill_ctrl.sv
// Scoreboard bench for rand_fill_ctrl with an external 8-bit Fibonacci LFSR.
module tb_rand_fill_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [2:0] rows;
  logic [2:0] cols;
  logic [3:0] val_min;
  logic [3:0] val_max;
  logic       lfsr_en;
  logic [7:0] lfsr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [3:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  rand_fill_ctrl #(
    .MAX_DIM   (5),
    .ELEM_W    (4),
    .MAX_RETRY (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .rows      (rows),
    .cols      (cols),
    .val_min   (val_min),
    .val_max   (val_max),
    .lfsr_en   (lfsr_en),
    .lfsr_data (lfsr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Shared LFSR x^8+x^6+x^5+x^4+1, shift left: FF -> FE -> FC -> F8 -> F0 ...
  logic [7:0] lfsr_q;
  logic       lfsr_load;
  logic [7:0] lfsr_seed;
  always_ff @(posedge clk) begin
    if (lfsr_load) lfsr_q <= lfsr_seed;
    else if (lfsr_en) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign lfsr_data = lfsr_q;

  typedef struct {
    int row;
    int col;
    int data;
  } exp_t;
  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int lfsr_cnt = 0;
  int wr_count = 0;
  int valid_cnt = 0;
  int stall_obs = 0;
  int lfsr_at_first = -1;
  bit first_pending = 0;
  int stall_left = 0;
  int cur_min = 0;
  int cur_max = 15;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int r, input int c, input int d);
    exp_t e;
    e.row = r; e.col = c; e.data = d;
    sb_q.push_back(e);
  endtask

  // wr_ready driver: holds ready low for stall_left WRITE cycles, else high.
  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (wr_valid && stall_left > 0) begin
        wr_ready = 1'b0;
        stall_left--;
      end else begin
        wr_ready = 1'b1;
      end
    end
  end

  // Monitor: counts pulses, checks hold during stalls, pops the scoreboard.
  initial begin
    bit         prev_stall;
    logic [2:0] prev_row;
    logic [2:0] prev_col;
    logic [3:0] prev_data;
    exp_t       e;
    prev_stall = 0;
    prev_row = '0; prev_col = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (lfsr_en) lfsr_cnt++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (wr_valid) valid_cnt++;
        if (prev_stall) begin
          chk("stall_hold", {21'd0, wr_valid, wr_row, wr_col, wr_data},
              {21'd0, 1'b1, prev_row, prev_col, prev_data});
        end
        if (wr_valid && !wr_ready && !abort) stall_obs++;
        if (wr_valid && wr_ready && !abort) begin
          wr_count++;
          if (first_pending) begin
            lfsr_at_first = lfsr_cnt;
            first_pending = 0;
          end
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got (%0d,%0d)=%0d expected no write", wr_row, wr_col, wr_data);
          end else begin
            e = sb_q.pop_front();
            $display("[TB] write (%0d,%0d) = %0d, expected (%0d,%0d) = %0d",
                     wr_row, wr_col, wr_data, e.row, e.col, e.data);
            chk("wr_row", wr_row, e.row);
            chk("wr_col", wr_col, e.col);
            chk("wr_data", wr_data, e.data);
            chk("wr_in_range", ((int'(wr_data) >= cur_min) && (int'(wr_data) <= cur_max)), 1);
          end
        end
        prev_stall = wr_valid && !wr_ready && !abort;
        prev_row = wr_row; prev_col = wr_col; prev_data = wr_data;
      end
    end
  end

  task automatic reseed(input logic [7:0] seed);
    @(posedge clk); #1;
    lfsr_seed = seed;
    lfsr_load = 1'b1;
    @(posedge clk); #1;
    lfsr_load = 1'b0;
  endtask

  task automatic do_start(input int r, input int c, input int mn, input int mx);
    @(posedge clk); #1;
    rows = 3'(r); cols = 3'(c); val_min = 4'(mn); val_max = 4'(mx);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_fill(input string name, input int r, input int c,
                          input int mn, input int mx, input bit exp_err);
    int d0, e0, v0;
    bit ended;
    d0 = done_cnt; e0 = err_cnt; v0 = valid_cnt;
    cur_min = mn; cur_max = mx;
    do_start(r, c, mn, mx);
    if (exp_err) begin
      @(posedge clk); #1;
      chk({name, "_busy_low"}, busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk({name, "_err_pulses"}, err_cnt - e0, 1);
      chk({name, "_no_valid"}, valid_cnt - v0, 0);
      chk({name, "_no_done"}, done_cnt - d0, 0);
    end else begin
      ended = 0;
      for (int i = 0; i < 600 && !ended; i++) begin
        @(posedge clk); #1;
        if (done_cnt != d0 || err_cnt != e0) ended = 1;
      end
      chk({name, "_ended"}, ended, 1);
      repeat (2) @(posedge clk);
      #1;
      chk({name, "_done_pulses"}, done_cnt - d0, 1);
      chk({name, "_no_err"}, err_cnt - e0, 0);
      chk({name, "_sb_empty"}, sb_q.size(), 0);
      chk({name, "_busy_low"}, busy, 0);
    end
    $display("[TB] %s finished: done=%0d err=%0d", name, done_cnt - d0, err_cnt - e0);
  endtask

  initial begin
    int  w0, d0, e0;
    bit  ok;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    rows = '0; cols = '0; val_min = '0; val_max = '0;
    lfsr_load = 1'b1; lfsr_seed = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_lfsr_en", lfsr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr_data", {wr_row, wr_col, wr_data}, 0);
    rst = 1'b0; lfsr_load = 1'b0;

    // 2x2 in [0,9] from seed FF: E, C rejected, 8 accepted; then 0, 1, 2.
    reseed(8'hFF);
    push(0, 0, 8); push(0, 1, 0); push(1, 0, 1); push(1, 1, 2);
    lfsr_cnt = 0; first_pending = 1;
    run_fill("t1_2x2_0_9", 2, 2, 0, 9, 0);
    chk("t1_lfsr_before_first", lfsr_at_first, 3);

    // 1x1 in [0,15]: first sample E accepted.
    reseed(8'hFF);
    push(0, 0, 14);
    run_fill("t2_1x1_0_15", 1, 1, 0, 15, 0);

    // Seed 85 gives B,7,F,E,C; range 5 rejects all, fallback 12 mod 5 -> 2+2.
    reseed(8'h85);
    push(0, 0, 4);
    lfsr_cnt = 0; first_pending = 1;
    run_fill("t3_fallback", 1, 1, 2, 6, 0);
    chk("t3_lfsr_before_first", lfsr_at_first, 5);

    // Backpressure: five stalled WRITE cycles, one write on release.
    reseed(8'hFF);
    push(0, 0, 14);
    stall_obs = 0; stall_left = 5;
    w0 = wr_count;
    run_fill("t4_stall", 1, 1, 0, 15, 0);
    chk("t4_stall_cycles", stall_obs, 5);
    chk("t4_one_write", wr_count - w0, 1);
    stall_left = 0;

    run_fill("t5_rows0", 0, 3, 0, 9, 1);
    run_fill("t5_min_gt_max", 2, 2, 7, 3, 1);
    run_fill("t5_rows_big", 6, 2, 0, 9, 1);

    // min = max = 5: every element is 5 regardless of the LFSR.
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) push(r, c, 5);
    run_fill("t6_3x3_const", 3, 3, 5, 5, 0);

    // Abort with start during the third WRITE.
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) push(r, c, 5);
    w0 = wr_count; d0 = done_cnt; e0 = err_cnt;
    cur_min = 5; cur_max = 5;
    do_start(3, 3, 5, 5);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      if (wr_count - w0 >= 2) ok = 1;
    end
    chk("t7_two_writes", ok, 1);
    stall_left = 3;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      if (wr_valid) ok = 1;
    end
    chk("t7_third_write_seen", ok, 1);
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk("t7_idle_after_abort", busy, 0);
    chk("t7_valid_dropped", wr_valid, 0);
    @(posedge clk); #1;
    chk("t7_start_ignored", busy, 0);
    chk("t7_no_done", done_cnt - d0, 0);
    chk("t7_no_err", err_cnt - e0, 0);
    chk("t7_writes_before_abort", wr_count - w0, 2);
    $display("[TB] t7_abort finished: writes=%0d", wr_count - w0);
    sb_q.delete();
    stall_left = 0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) push(r, c, 5);
    run_fill("t7_restart", 3, 3, 5, 5, 0);

    // Mid-fill reset.
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) push(r, c, 5);
    w0 = wr_count;
    do_start(3, 3, 5, 5);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      if (wr_count - w0 >= 1) ok = 1;
    end
    chk("t8_first_write", ok, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t8_busy", busy, 0);
    chk("t8_wr_valid", wr_valid, 0);
    chk("t8_lfsr_en", lfsr_en, 0);
    chk("t8_done_err", {done, err}, 0);
    chk("t8_addr_data", {wr_row, wr_col, wr_data}, 0);
    rst = 1'b0;
    sb_q.delete();
    $display("[TB] t8_midfill_reset finished");
    push(0, 0, 5); push(0, 1, 5);
    run_fill("t8_recover", 1, 2, 5, 5, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
